// File: rtl/scanner_link_pkg.sv
// Shared opcode constants and receiver state encoding for the scanner serial link.
// The scanner transmitter compiles against the same package.
package scanner_link_pkg;

  localparam logic [7:0] OP_READY_XFER = 8'd2;
  localparam logic [7:0] OP_START_SCAN = 8'd3;
  localparam logic [7:0] OP_BUF_FULL   = 8'd4;
  localparam logic [7:0] OP_DATA       = 8'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/scanner_link_rx_if.sv
// Serial link pins plus the strobe bus toward the transfer controller; master = receiver side.
// Counter signals exist only when SCANNER_LINK_RX_STATS_EN is defined.
interface scanner_link_rx_if;
  logic       ser_clk;
  logic       ser_data;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       ready_xfer;
  logic       start_scan;
  logic       buf_full;
  logic       data_valid;
  logic [7:0] data_out;
  logic       frame_err;
  logic       busy;
`ifdef SCANNER_LINK_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  modport master (
    input  ser_clk, ser_data,
    output cmd_valid, cmd_code, ready_xfer, start_scan, buf_full,
    output data_valid, data_out, frame_err, busy, frame_cnt, err_cnt
  );
  modport slave (
    output ser_clk, ser_data,
    input  cmd_valid, cmd_code, ready_xfer, start_scan, buf_full,
    input  data_valid, data_out, frame_err, busy, frame_cnt, err_cnt
  );
`else
  modport master (
    input  ser_clk, ser_data,
    output cmd_valid, cmd_code, ready_xfer, start_scan, buf_full,
    output data_valid, data_out, frame_err, busy
  );
  modport slave (
    output ser_clk, ser_data,
    input  cmd_valid, cmd_code, ready_xfer, start_scan, buf_full,
    input  data_valid, data_out, frame_err, busy
  );
`endif
endinterface

// File: rtl/scanner_link_sync.sv
// Two-flop synchronizers for ser_clk/ser_data plus a registered rising-edge detector.
// Edge and sampled bit appear 3 clk cycles after the pin transition.
module scanner_link_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_ser_clk,
  input  logic i_ser_data,
  output logic o_edge_pulse,
  output logic o_bit_sampled
);

  logic       r_clk_meta, r_clk_sync, r_clk_d;
  logic       r_dat_meta, r_dat_sync;
  logic       r_edge, r_bit;
  logic [1:0] r_blank;

  // Edges are masked until the synchronizer holds real pin values, so a
  // ser_clk already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b0;
      r_clk_sync <= 1'b0;
      r_clk_d    <= 1'b0;
      r_dat_meta <= 1'b0;
      r_dat_sync <= 1'b0;
      r_edge     <= 1'b0;
      r_bit      <= 1'b0;
      r_blank    <= 2'd3;
    end else begin
      r_clk_meta <= i_ser_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_d    <= r_clk_sync;
      r_dat_meta <= i_ser_data;
      r_dat_sync <= r_dat_meta;
      r_edge     <= r_clk_sync & ~r_clk_d & (r_blank == 2'd0);
      r_bit      <= r_dat_sync;
      if (r_blank != 2'd0) r_blank <= r_blank - 2'd1;
    end
  end

  assign o_edge_pulse  = r_edge;
  assign o_bit_sampled = r_bit;

endmodule

// File: rtl/scanner_link_rx.sv
// Frames LSB-first bytes off the scanner link, decodes opcodes and strobes the transfer controller.
// Strobes land 4 clk after the 8th ser_clk rise; SCANNER_LINK_RX_STATS_EN adds frame/error counters.
module scanner_link_rx
  import scanner_link_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic              clk,
  input  logic              rst,
  scanner_link_rx_if.master bus
);

  logic w_edge, w_bit;

  scanner_link_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .i_ser_clk    (bus.ser_clk),
    .i_ser_data   (bus.ser_data),
    .o_edge_pulse (w_edge),
    .o_bit_sampled(w_bit)
  );

  rx_state_t       r_state, w_state_nxt;
  logic [2:0]      r_bitcnt, w_bitcnt_nxt;
  logic [7:0]      r_shreg, w_shreg_nxt, w_byte;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            w_to_hit;
  logic [7:0]      r_cmd_code, w_cmd_code_nxt;
  logic [7:0]      r_data_out, w_data_out_nxt;
  logic            r_cmd_valid, w_cmd_valid_nxt;
  logic            r_ready_xfer, w_ready_xfer_nxt;
  logic            r_start_scan, w_start_scan_nxt;
  logic            r_buf_full, w_buf_full_nxt;
  logic            r_data_valid, w_data_valid_nxt;
  logic            r_frame_err, w_frame_err_nxt;

  always_comb begin
    w_state_nxt      = r_state;
    w_bitcnt_nxt     = r_bitcnt;
    w_shreg_nxt      = r_shreg;
    w_cmd_code_nxt   = r_cmd_code;
    w_data_out_nxt   = r_data_out;
    w_cmd_valid_nxt  = 1'b0;
    w_ready_xfer_nxt = 1'b0;
    w_start_scan_nxt = 1'b0;
    w_buf_full_nxt   = 1'b0;
    w_data_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_byte           = {w_bit, r_shreg[7:1]};
    // An edge in the same cycle always beats the timeout.
    w_to_hit         = !w_edge && (r_to_cnt == TO_W'(IDLE_TIMEOUT - 1));

    if (w_edge)
      w_to_cnt_nxt = '0;
    else if (r_to_cnt != TO_W'(IDLE_TIMEOUT))
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    else
      w_to_cnt_nxt = r_to_cnt;

    if (w_edge) begin
      w_shreg_nxt  = w_byte;
      w_bitcnt_nxt = r_bitcnt + 3'd1;
      unique case (r_state)
        IDLE: w_state_nxt = CMD;
        CMD: begin
          if (r_bitcnt == 3'd7) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_code_nxt  = w_byte;
            w_state_nxt     = IDLE;
            case (w_byte)
              OP_READY_XFER: w_ready_xfer_nxt = 1'b1;
              OP_START_SCAN: w_start_scan_nxt = 1'b1;
              OP_BUF_FULL:   w_buf_full_nxt   = 1'b1;
              OP_DATA:       w_state_nxt      = DATA;
              default:       w_frame_err_nxt  = 1'b1;
            endcase
          end
        end
        DATA: begin
          if (r_bitcnt == 3'd7) begin
            w_data_valid_nxt = 1'b1;
            w_data_out_nxt   = w_byte;
            w_state_nxt      = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_to_hit && (r_bitcnt != 3'd0 || r_state == DATA)) begin
      w_frame_err_nxt = 1'b1;
      w_bitcnt_nxt    = 3'd0;
      w_state_nxt     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bitcnt     <= 3'd0;
      r_shreg      <= 8'd0;
      r_to_cnt     <= '0;
      r_cmd_code   <= 8'd0;
      r_data_out   <= 8'd0;
      r_cmd_valid  <= 1'b0;
      r_ready_xfer <= 1'b0;
      r_start_scan <= 1'b0;
      r_buf_full   <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_cmd_code   <= w_cmd_code_nxt;
      r_data_out   <= w_data_out_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_ready_xfer <= w_ready_xfer_nxt;
      r_start_scan <= w_start_scan_nxt;
      r_buf_full   <= w_buf_full_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_code   = r_cmd_code;
  assign bus.ready_xfer = r_ready_xfer;
  assign bus.start_scan = r_start_scan;
  assign bus.buf_full   = r_buf_full;
  assign bus.data_valid = r_data_valid;
  assign bus.data_out   = r_data_out;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state != IDLE) || (r_bitcnt != 3'd0);

`ifdef SCANNER_LINK_RX_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      if (w_cmd_valid_nxt && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_frame_err_nxt && r_err_cnt != 16'hFFFF)   r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_scanner_link_rx.sv
// Directed bench for scanner_link_rx: framing, decode, timeout, reset and optional counters.
// Serial link driven at 8 clk per ser_clk period; strobes checked at the exact landing cycle.
module tb_scanner_link_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scanner_link_rx_if bus ();

  scanner_link_rx #(.IDLE_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Pulse counters sampled mid-cycle, away from the active edge.
  int cnt_cmd = 0, cnt_rdy = 0, cnt_start = 0, cnt_full = 0, cnt_data = 0, cnt_ferr = 0;
  always @(negedge clk) begin
    if (bus.cmd_valid)  cnt_cmd++;
    if (bus.ready_xfer) cnt_rdy++;
    if (bus.start_scan) cnt_start++;
    if (bus.buf_full)   cnt_full++;
    if (bus.data_valid) cnt_data++;
    if (bus.frame_err)  cnt_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // After the last bit the call returns exactly 4 clk past the 8th ser_clk rise.
  task automatic send_bit(input logic b);
    bus.ser_data = b;
    bus.ser_clk  = 1'b0;
    tick(4);
    bus.ser_clk  = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    bus.ser_clk = 1'b0;
    tick(n);
  endtask

  function automatic logic [6:0] strobes();
    return {bus.cmd_valid, bus.ready_xfer, bus.start_scan, bus.buf_full,
            bus.data_valid, bus.frame_err, bus.busy};
  endfunction

  int b_cmd, b_rdy, b_data, b_ferr;

  task automatic snap();
    b_cmd  = cnt_cmd;
    b_rdy  = cnt_rdy;
    b_data = cnt_data;
    b_ferr = cnt_ferr;
  endtask

  initial begin
    bus.ser_clk  = 1'b0;
    bus.ser_data = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_strobes", 32'(strobes()), 32'h0);
    check("rst_cmd_code", 32'(bus.cmd_code), 32'h0);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    rst = 1'b0;
    tick(5);

    // Opcode 2: pulse lands 4 cycles after the 8th edge and lasts one cycle.
    snap();
    send_byte(8'h02);
    check("t1_cmd_valid", 32'(bus.cmd_valid), 32'h1);
    check("t1_ready_xfer", 32'(bus.ready_xfer), 32'h1);
    check("t1_cmd_code", 32'(bus.cmd_code), 32'h02);
    check("t1_start_scan", 32'(bus.start_scan), 32'h0);
    tick(1);
    check("t1_cmd_valid_fall", 32'(bus.cmd_valid), 32'h0);
    idle(30);
    check("t1_busy", 32'(bus.busy), 32'h0);
    check("t1_n_cmd", 32'(cnt_cmd - b_cmd), 32'd1);
    check("t1_n_rdy", 32'(cnt_rdy - b_rdy), 32'd1);
    check("t1_n_ferr", 32'(cnt_ferr - b_ferr), 32'd0);

    // Data opcode followed by payload byte.
    snap();
    send_byte(8'h07);
    check("t2_cmd_valid", 32'(bus.cmd_valid), 32'h1);
    check("t2_cmd_code", 32'(bus.cmd_code), 32'h07);
    check("t2_busy_data", 32'(bus.busy), 32'h1);
    send_byte(8'hA5);
    check("t2_data_valid", 32'(bus.data_valid), 32'h1);
    check("t2_data_out", 32'(bus.data_out), 32'hA5);
    check("t2_cmd_valid_lo", 32'(bus.cmd_valid), 32'h0);
    idle(30);
    check("t2_n_ferr", 32'(cnt_ferr - b_ferr), 32'd0);
    check("t2_n_data", 32'(cnt_data - b_data), 32'd1);

    // Start scan then buffer full.
    send_byte(8'h03);
    check("t3_start_scan", 32'(bus.start_scan), 32'h1);
    check("t3_cmd_code", 32'(bus.cmd_code), 32'h03);
    send_byte(8'h04);
    check("t3_buf_full", 32'(bus.buf_full), 32'h1);
    check("t3_start_lo", 32'(bus.start_scan), 32'h0);
    idle(30);
    check("t3_cmd_code_hold", 32'(bus.cmd_code), 32'h04);

    // Partial byte abandoned by timeout.
    snap();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t4_busy_partial", 32'(bus.busy), 32'h1);
    idle(30);
    check("t4_n_ferr", 32'(cnt_ferr - b_ferr), 32'd1);
    check("t4_n_cmd", 32'(cnt_cmd - b_cmd), 32'd0);
    check("t4_busy_after", 32'(bus.busy), 32'h0);
    send_byte(8'h02);
    check("t4_ready_xfer", 32'(bus.ready_xfer), 32'h1);
    check("t4_cmd_code", 32'(bus.cmd_code), 32'h02);
    idle(30);

    // Unknown opcode, then data opcode with missing payload.
    send_byte(8'h09);
    check("t5_cmd_valid", 32'(bus.cmd_valid), 32'h1);
    check("t5_frame_err", 32'(bus.frame_err), 32'h1);
    check("t5_cmd_code", 32'(bus.cmd_code), 32'h09);
    idle(30);
    snap();
    send_byte(8'h07);
    check("t5_cmd_valid_07", 32'(bus.cmd_valid), 32'h1);
    check("t5_frame_err_07", 32'(bus.frame_err), 32'h0);
    idle(30);
    check("t5_n_ferr", 32'(cnt_ferr - b_ferr), 32'd1);
    check("t5_n_data", 32'(cnt_data - b_data), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'h0);

    // Reset mid-frame, released with ser_clk still high.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    tick(1);
    check("t6_rst_strobes", 32'(strobes()), 32'h0);
    check("t6_rst_cmd_code", 32'(bus.cmd_code), 32'h0);
    check("t6_rst_data_out", 32'(bus.data_out), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(8);
    check("t6_no_spurious_edge", 32'(bus.busy), 32'h0);
    send_byte(8'h02);
    check("t6_ready_xfer", 32'(bus.ready_xfer), 32'h1);
    check("t6_cmd_code", 32'(bus.cmd_code), 32'h02);
    check("t6_frame_err", 32'(bus.frame_err), 32'h0);
    idle(30);
`ifdef SCANNER_LINK_RX_STATS_EN
    check("t6_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check("t6_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    check("t6_busy", 32'(bus.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scanner_link_rx.md
Name: scanner_link_rx

Overview:
- Downstream receiver for a scanner's serial command/data link.
- Samples the link's `ser_clk`/`ser_data` pair in the system `clk` domain and frames 8-bit LSB-first bytes.
- Decodes command opcodes. After opcode `OP_DATA`, the next byte is captured as data payload.
- Feeds the transfer controller with one-cycle command/data strobes and framing-error reports.

Parameters:
- `IDLE_TIMEOUT`, default 16: `clk` cycles without a `ser_clk` rising edge before a partial frame is abandoned.
- `TO_W`, default 5: width of the timeout counter. Must satisfy `2**TO_W > IDLE_TIMEOUT`.

Ports:
- `clk` in 1: system clock. All logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `ser_clk` in 1: serial link clock from the scanner. Asynchronous to `clk`.
- `ser_data` in 1: serial link data, LSB first, valid at `ser_clk` rising edge.
- `cmd_valid` out 1: one-cycle strobe, command byte received.
- `cmd_code` out 8: received opcode. Held until the next `cmd_valid`.
- `ready_xfer` out 1: one-cycle pulse on opcode 2 (READY_TO_TRANSFER).
- `start_scan` out 1: one-cycle pulse on opcode 3 (START_SCANNING).
- `buf_full` out 1: one-cycle pulse on opcode 4 (buffer full / TRANSFER).
- `data_valid` out 1: one-cycle strobe, payload byte received.
- `data_out` out 8: payload byte. Held until the next `data_valid`.
- `frame_err` out 1: one-cycle pulse on timeout mid-byte or unknown opcode.
- `busy` out 1: high while state is not `IDLE` or the bit count is nonzero.

Behaviour:
- Input synchronization:
  - `ser_clk` and `ser_data` each pass through 2-flop synchronizers.
  - Rising-edge detect compares the synced clock with a third register.
  - Data is sampled from the synced `ser_data` in the same cycle the edge is detected.
- Shifting:
  - Each detected edge shifts the sampled bit in MSB-ward: `shreg <= {bit, shreg[7:1]}`. Bit 0 arrives first.
  - `bitcnt` (3 bits) increments per edge and wraps 7→0. The wrap marks byte complete.
- Latency:
  - Strobes (`cmd_valid`/`data_valid`/decode pulses/`frame_err`) are registered.
  - They assert exactly 4 `clk` cycles after the 8th `ser_clk` rising edge reaches the pin.
  - Breakdown: 2 sync + 1 edge register + 1 output register.
- States: `IDLE`, `CMD`, `DATA`.
  - `IDLE`: the first edge moves to `CMD` with bit 0 shifted in.
  - `CMD`, byte complete:
    - Opcode 2/3/4: `cmd_valid` plus the matching decode pulse; go to `IDLE`.
    - Opcode 7: `cmd_valid`; go to `DATA`.
    - Any other opcode: `cmd_valid` and `frame_err`; go to `IDLE`.
  - `DATA`, byte complete: `data_valid`, `data_out` = byte; go to `IDLE`.
  - `IDLE` with a new edge before any timeout: back-to-back frames are allowed and start a new `CMD` byte.
- Timeout:
  - The counter clears on every edge and increments otherwise, saturating.
  - Reaching `IDLE_TIMEOUT` while `bitcnt != 0`, or while state is `DATA`:
    - `frame_err` pulse;
    - `bitcnt` := 0, state := `IDLE`;
    - partial byte discarded, no `cmd_valid`/`data_valid`.
  - Reaching it in `IDLE` with `bitcnt == 0`: no effect.
- Simultaneous events: an edge and a timeout in the same cycle → the edge wins and the counter clears.
- Reset, including mid-frame:
  - all outputs 0, `cmd_code`/`data_out` = 0;
  - state `IDLE`, `bitcnt` 0;
  - synchronizers cleared to 0;
  - timeout counter 0.
  - A `ser_clk` already high at reset release does not produce an edge.
- Only one strobe group is active per cycle. `frame_err` may coincide with `cmd_valid` only for an unknown opcode.

Optional Feature:
- `SCANNER_LINK_RX_STATS_EN` defined:
  - Adds outputs `frame_cnt` [15:0] and `err_cnt` [15:0].
  - Both are saturating at 16'hFFFF and cleared by `rst`.
  - `frame_cnt` increments on each `cmd_valid`; `err_cnt` on each `frame_err`.
- Undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- `scanner_link_pkg`:
  - opcode constants `OP_READY_XFER`=8'd2, `OP_START_SCAN`=8'd3, `OP_BUF_FULL`=8'd4, `OP_DATA`=8'd7;
  - state enum `rx_state_t` {`IDLE`, `CMD`, `DATA`}.
  - The scanner transmitter uses the same constants.
- Sub-module `scanner_link_sync`: dual 2-flop synchronizer plus rising-edge detector. Outputs `edge_pulse` and `bit_sampled`.

Test Plan:
- Send byte 0x02 LSB-first, `ser_clk` period 8 `clk`:
  - `cmd_valid` and `ready_xfer` high 1 cycle, `cmd_code`=0x02, 4 cycles after the 8th edge;
  - `busy` low afterwards.
- Send 0x07 then 0xA5 back-to-back: `cmd_valid` with 0x07, then `data_valid` with `data_out`=0xA5; no `frame_err`.
- Send 0x03 then 0x04 → `start_scan` pulse, then `buf_full` pulse. `cmd_code` holds 0x04 after the second.
- Send 5 bits, then hold `ser_clk` low for 20 cycles → `frame_err` once; no `cmd_valid`; next full 0x02 decodes correctly.
- Send 0x09 → `cmd_valid` with `cmd_code`=0x09 plus `frame_err` in the same cycle. Send 0x07, then idle 20 cycles → `frame_err`, no `data_valid`.
- Assert `rst` after 4 bits of a byte: all outputs 0 next cycle; a following 0x02 decodes cleanly. With `SCANNER_LINK_RX_STATS_EN`: `frame_cnt`=1, `err_cnt`=0.
